// File: rtl/led_mode_sequencer.sv
// led_mode_sequencer: prescaled pattern stepper for an 8-LED bank with a debounced mode button
module led_mode_sequencer #(
  parameter int CLKDIV        = 21,
  parameter int DEBOUNCE_BITS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  output logic [7:0] led,
  output logic [1:0] mode,
  output logic       tick
);
  typedef enum logic [1:0] {COUNT, SCAN, BLINK, HOLD} mode_t;
  localparam logic LEFT = 1'b0;
  mode_t                    state, state_n;
  logic [7:0]               led_n;
  logic                     dir, dir_n;
  logic [CLKDIV-1:0]        div;
  logic [1:0]               sync;
  logic                     deb, deb_q;
  logic [DEBOUNCE_BITS-1:0] cnt;
  logic                     press;
  // free-running prescaler; tick is registered so it lands the cycle after div wraps
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      div  <= '0;
      tick <= 1'b0;
    end else begin
      div  <= div + 1'b1;
      tick <= &div;
    end
  // two-flop synchronizer and debounce filter; deb_q lets press fire once per rising edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync  <= '0;
      deb   <= 1'b0;
      deb_q <= 1'b0;
      cnt   <= '0;
    end else begin
      sync  <= {sync[0], btn};
      deb_q <= deb;
      if (sync[1] == deb) cnt <= '0;
      else if (&cnt) begin
        deb <= sync[1];
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  assign press = deb & ~deb_q;
  // mode advance with entry loads; a press in a tick cycle swallows that tick
  always_comb begin
    state_n = state;
    led_n   = led;
    dir_n   = dir;
    if (press)
      case (state)
        COUNT: begin
          state_n = SCAN;
          led_n   = 8'h01;
          dir_n   = LEFT;
        end
        SCAN: begin
          state_n = BLINK;
          led_n   = 8'hff;
        end
        BLINK:   state_n = HOLD;
        default: begin
          state_n = COUNT;
          led_n   = 8'h00;
        end
      endcase
    else if (tick)
      case (state)
        COUNT: led_n = led + 8'd1;
        SCAN: begin
          led_n = (dir == LEFT) ? led << 1 : led >> 1;
          dir_n = (dir == LEFT) ? (led == 8'h40) : (led != 8'h02);
        end
        BLINK:   led_n = ~led;
        default: led_n = led;
      endcase
  end
  // mode, pattern and scan direction registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= COUNT;
      led   <= 8'h00;
      dir   <= LEFT;
    end else begin
      state <= state_n;
      led   <= led_n;
      dir   <= dir_n;
    end
  assign mode = state;
endmodule

// File: doc/led_mode_sequencer.md
Name: led_mode_sequencer

Overview:
Controller that sequences the 8-LED bank through selectable display patterns on the iCE40 board.
- A prescaler generates the pattern step tick.
- A debounced push button cycles the display mode.
- A 4-state mode FSM drives the 8-bit pattern register onto the LEDs.
- Sits between the board clock/button pins and the LED pins; top level wires led[7:0] to LED0..LED7, with led[7] driving LED0.

Parameters:
CLKDIV, 21, prescaler width; tick period = 2^CLKDIV clk cycles
DEBOUNCE_BITS, 16, button must differ from debounced state for 2^DEBOUNCE_BITS consecutive cycles to be accepted

Ports:
clk  input  1  board clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
btn  input  1  raw push button, active-high, asynchronous to clk
led  output  8  registered LED pattern
mode  output  2  current mode: 0 COUNT, 1 SCAN, 2 BLINK, 3 HOLD
tick  output  1  one-cycle prescaler pulse

Behaviour:
Reset (rst_n low, immediate, no clk needed):
- div=0, tick=0, sync regs=0, debounced=0, debounce cnt=0.
- mode=COUNT, led=8'h00, scan dir=LEFT.
- Reset mid-operation aborts everything; no pattern state survives.

Prescaler:
- div (CLKDIV bits) increments every cycle and wraps.
- tick=1 for exactly the cycle after div==all-ones, i.e. tick is registered.
- First tick is the 2^CLKDIV-th cycle after reset release; period is exactly 2^CLKDIV thereafter.
- The prescaler is never stopped or reset by mode changes.

Button:
- 2-FF synchronizer feeds btn_s.
- Debounce counter clears whenever btn_s==debounced, else increments.
- When the counter reaches 2^DEBOUNCE_BITS-1 and btn_s still differs, debounced<=btn_s and the counter clears.
- press = the cycle in which debounced goes 0->1 (one pulse per press). Release generates no event.

Mode FSM (advances only on press):
- Order: COUNT -> SCAN -> BLINK -> HOLD -> COUNT.
- Entry loads, on the same clk edge as the mode change:
  - COUNT: led=00.
  - SCAN: led=01, dir=LEFT.
  - BLINK: led=FF.
  - HOLD: led unchanged.

Pattern update on tick (when no press that cycle):
- COUNT: led<=led+1, 8-bit modulo; FF wraps to 00.
- SCAN: dir LEFT shifts left; on reaching 80, dir becomes RIGHT. Dir RIGHT shifts right; on reaching 01, dir becomes LEFT. Only one bit is ever set, and there is no dwell at the ends: sequence 01,02,..,80,40,..,01,02.
- BLINK: led<=~led.
- HOLD: no change.

Simultaneous events:
- press and tick in the same cycle: the mode change and entry load win; the tick is dropped for pattern purposes.

Output timing:
- led and mode are registered; no combinational path from btn to outputs.
- Latency from btn edge to mode change: 2 sync cycles + 2^DEBOUNCE_BITS cycles + 1 cycle.

Test Plan:
All scenarios use CLKDIV=3 (tick every 8 cycles) and DEBOUNCE_BITS=2 (4 stable cycles).
1. Reset/prescaler: assert rst_n low mid-cycle -> led=00, mode=0, tick=0 with no clock edge. Release -> first tick on cycle 8, then every 8 cycles. After 256 ticks in COUNT, led returns to 00 (FF->00 wrap checked).
2. Debounce: btn high for 3 cycles then low -> mode stays 0. btn high for 12 cycles -> exactly one transition to mode=1 with led=01. Hold btn high for 100 cycles -> no further transition.
3. SCAN bounce: from 01, 7 ticks -> 02,04,08,10,20,40,80; next 7 ticks -> 40,20,10,08,04,02,01; next tick -> 02.
4. BLINK/HOLD: press from SCAN -> mode=2, led=FF; ticks -> 00, FF. Press -> mode=3, led frozen over 5 ticks. Press -> mode=0, led=00; next tick -> 01.
5. Collision: time the press so debounced rises in a tick cycle while in COUNT with led=05 -> mode=1, led=01 (not 06). Next tick -> 02.
6. Reset mid-SCAN: in SCAN at led=20, dir RIGHT, pulse rst_n low -> mode=0, led=00. Release, then press -> SCAN restarts at 01 moving LEFT.
